// File: rtl/conv2_pe_sequencer.sv
// conv2_pe_sequencer: feeds a two-tap PE across a stride-1 1-D convolution row, then applies bias/rescale/ReLU/saturate and streams results.
module conv2_pe_sequencer #(
  parameter int N_TAPS = 8,
  parameter int IN_LEN = 64,
  parameter int ADDR_W = 8,
  parameter int ACC_W = 40,
  parameter int RELU = 1,
  localparam int P = N_TAPS / 2,
  localparam int PW = (P > 1) ? $clog2(P) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] x_addr0,
  output logic [ADDR_W-1:0] x_addr1,
  output logic              x_rd_en,
  input  logic [15:0]       x_rdata0,
  input  logic [15:0]       x_rdata1,
  output logic [PW-1:0]     w_addr,
  input  logic [15:0]       w_rdata0,
  input  logic [15:0]       w_rdata1,
  input  logic [15:0]       bias,
  output logic              pe_start,
  output logic [15:0]       pe_x0,
  output logic [15:0]       pe_x1,
  output logic [15:0]       pe_w0,
  output logic [15:0]       pe_w1,
  input  logic [31:0]       pe_odata,
  output logic [15:0]       y_data,
  output logic [ADDR_W-1:0] y_idx,
  output logic              y_valid,
  input  logic              y_ready
);
  localparam int OUT_LEN = IN_LEN - N_TAPS + 1;
  localparam logic signed [ACC_W-1:0] MAXV = ACC_W'(32767);
  localparam logic signed [ACC_W-1:0] MINV = ACC_W'(-32768);
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, OUT, DONE} state_t;
  state_t state, state_n;
  logic [PW-1:0] p;
  logic [1:0] dcnt;
  logic [ADDR_W-1:0] o, base;
  logic pe_v, fetch, last_p, last_o;
  logic signed [ACC_W-1:0] acc, sum, r, rr;
  logic [15:0] res;
  assign fetch = state == FETCH;
  assign last_p = p == PW'(P - 1);
  assign last_o = o == ADDR_W'(OUT_LEN - 1);
  assign base = o + ADDR_W'({p, 1'b0});
  assign busy = (state != IDLE) && (state != DONE);
  assign done = state == DONE;
  assign y_valid = state == OUT;
  assign x_rd_en = fetch;
  assign x_addr0 = fetch ? base : '0;
  assign x_addr1 = fetch ? base + 1'b1 : '0;
  assign w_addr = fetch ? p : '0;
  // Buffer/ROM data lands one cycle after the read; it is presented to the PE only while pe_start is high.
  assign pe_x0 = pe_start ? x_rdata0 : '0;
  assign pe_x1 = pe_start ? x_rdata1 : '0;
  assign pe_w0 = pe_start ? w_rdata0 : '0;
  assign pe_w1 = pe_start ? w_rdata1 : '0;
  assign sum = acc + {{(ACC_W-24){bias[15]}}, bias, 8'd0};
  assign r = sum >>> 8;
  assign rr = (RELU != 0 && r[ACC_W-1]) ? '0 : r;
  assign res = rr > MAXV ? 16'h7fff : rr < MINV ? 16'h8000 : rr[15:0];
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = start ? FETCH : IDLE;
      FETCH:   state_n = last_p ? DRAIN : FETCH;
      DRAIN:   state_n = dcnt == 2'd2 ? OUT : DRAIN;
      OUT:     state_n = y_ready ? (last_o ? DONE : FETCH) : OUT;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // DRAIN covers the two in-flight PE cycles plus one cycle to form the result from the settled accumulator.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
      dcnt <= '0;
      o <= '0;
      pe_start <= 1'b0;
      pe_v <= 1'b0;
      acc <= '0;
      y_data <= '0;
      y_idx <= '0;
    end else begin
      pe_start <= fetch;
      pe_v <= pe_start;
      p <= (fetch && !last_p) ? p + 1'b1 : '0;
      dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
      if (state == IDLE && start) o <= '0;
      else if (state == OUT && y_ready && !last_o) o <= o + 1'b1;
      if (fetch && p == '0) acc <= '0;
      else if (pe_v) acc <= acc + {{(ACC_W-32){pe_odata[31]}}, pe_odata};
      if (state == DRAIN && dcnt == 2'd2) begin
        y_data <= res;
        y_idx <= o;
      end
    end
  end
endmodule

// File: tb/tb_conv2_pe_sequencer.sv
// tb_conv2_pe_sequencer: ReLU and non-ReLU instances run in lockstep against a tap-sum reference model.
module tb_conv2_pe_sequencer;
  localparam int N_TAPS = 4;
  localparam int IN_LEN = 8;
  localparam int P = N_TAPS / 2;
  localparam int OUT_LEN = IN_LEN - N_TAPS + 1;
  logic clk = 1'b0, rst, start, y_ready;
  logic [15:0] bias;
  logic busy[2], done[2], x_rd_en[2], pe_start[2], y_valid[2];
  logic [7:0] x_addr0[2], x_addr1[2], y_idx[2];
  logic [0:0] w_addr[2];
  logic [15:0] x_rdata0[2], x_rdata1[2], w_rdata0[2], w_rdata1[2];
  logic [15:0] pe_x0[2], pe_x1[2], pe_w0[2], pe_w1[2], y_data[2];
  logic [31:0] pe_odata[2];
  logic [15:0] xmem[256];
  logic [15:0] wmem[N_TAPS];
  int nvec = 0, nerr = 0, cyc = 0, k = 0, next_o = 0, rows_done = 0;
  bit running = 0, done_due = 0, trk = 0;
  logic [15:0] got_y[2][OUT_LEN];
  logic [7:0] got_idx[OUT_LEN];
  int hs_cyc[OUT_LEN];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : u
    conv2_pe_sequencer #(.N_TAPS(N_TAPS), .IN_LEN(IN_LEN), .ADDR_W(8), .ACC_W(40), .RELU(g == 0 ? 1 : 0)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy[g]), .done(done[g]),
      .x_addr0(x_addr0[g]), .x_addr1(x_addr1[g]), .x_rd_en(x_rd_en[g]),
      .x_rdata0(x_rdata0[g]), .x_rdata1(x_rdata1[g]), .w_addr(w_addr[g]),
      .w_rdata0(w_rdata0[g]), .w_rdata1(w_rdata1[g]), .bias(bias),
      .pe_start(pe_start[g]), .pe_x0(pe_x0[g]), .pe_x1(pe_x1[g]), .pe_w0(pe_w0[g]), .pe_w1(pe_w1[g]),
      .pe_odata(pe_odata[g]), .y_data(y_data[g]), .y_idx(y_idx[g]), .y_valid(y_valid[g]), .y_ready(y_ready)
    );
  end
  // Environment: registered line buffer, weight ROM and a registered two-tap PE per instance.
  always @(posedge clk)
    for (int i = 0; i < 2; i++) begin
      if (x_rd_en[i]) begin
        x_rdata0[i] <= xmem[x_addr0[i]];
        x_rdata1[i] <= xmem[x_addr1[i]];
        w_rdata0[i] <= wmem[2 * int'(w_addr[i])];
        w_rdata1[i] <= wmem[2 * int'(w_addr[i]) + 1];
      end
      if (pe_start[i])
        pe_odata[i] <= 32'(int'($signed(pe_x0[i])) * int'($signed(pe_w0[i])) + int'($signed(pe_x1[i])) * int'($signed(pe_w1[i])));
    end
  function automatic logic [15:0] ref_y(input int o, input bit relu);
    longint acc = 0;
    longint r;
    for (int q = 0; q < P; q++) begin
      int s;
      s = int'($signed(xmem[o + 2 * q])) * int'($signed(wmem[2 * q])) + int'($signed(xmem[o + 2 * q + 1])) * int'($signed(wmem[2 * q + 1]));
      acc += longint'(s);
    end
    acc += longint'($signed(bias)) * 256;
    r = acc >>> 8;
    if (relu && r < 0) r = 0;
    if (r > 32767) r = 32767;
    if (r < -32768) r = -32768;
    return r[15:0];
  endfunction
  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s[%0d] at cycle %0d: got %h, expected %h", nm, i, cyc, got, exp);
    end
  endtask
  always @(negedge clk) begin
    bit ev, dd;
    cyc++;
    if (rst) begin
      running = 0; done_due = 0; trk = 0; k = 0; next_o = 0;
    end else begin
      if (trk) k++;
      ev = trk && k >= P + 4;
      for (int i = 0; i < 2; i++) begin
        chk("busy", i, busy[i], running);
        chk("done", i, done[i], done_due);
        chk("y_valid", i, y_valid[i], ev);
        chk("x_rd_en", i, x_rd_en[i], trk && k >= 1 && k <= P);
        chk("pe_start", i, pe_start[i], trk && k >= 2 && k <= P + 1);
        if (trk && k >= 1 && k <= P) begin
          chk("x_addr0", i, x_addr0[i], next_o + 2 * (k - 1));
          chk("x_addr1", i, x_addr1[i], next_o + 2 * (k - 1) + 1);
          chk("w_addr", i, w_addr[i], k - 1);
        end
        if (trk && k >= 2 && k <= P + 1) begin
          chk("pe_x0", i, pe_x0[i], xmem[next_o + 2 * (k - 2)]);
          chk("pe_x1", i, pe_x1[i], xmem[next_o + 2 * (k - 2) + 1]);
          chk("pe_w0", i, pe_w0[i], wmem[2 * (k - 2)]);
          chk("pe_w1", i, pe_w1[i], wmem[2 * (k - 2) + 1]);
        end
        if (ev) begin
          chk("y_idx", i, y_idx[i], next_o);
          chk("y_data", i, y_data[i], ref_y(next_o, i == 0));
        end
      end
      dd = done_due;
      done_due = 0;
      if (ev && y_ready) begin
        got_y[0][next_o] = y_data[0];
        got_y[1][next_o] = y_data[1];
        got_idx[next_o] = y_idx[0];
        hs_cyc[next_o] = cyc;
        if (next_o == OUT_LEN - 1) begin
          trk = 0; running = 0; done_due = 1; rows_done++;
        end else begin
          next_o++; k = 0;
        end
      end else if (!running && !dd && start) begin
        running = 1; trk = 1; k = 0; next_o = 0;
      end
    end
  end
  task automatic check_zero();
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy", i, busy[i], 0); chk("rst_done", i, done[i], 0);
      chk("rst_rd_en", i, x_rd_en[i], 0); chk("rst_pe_start", i, pe_start[i], 0);
      chk("rst_y_valid", i, y_valid[i], 0); chk("rst_x_addr0", i, x_addr0[i], 0);
      chk("rst_x_addr1", i, x_addr1[i], 0); chk("rst_w_addr", i, w_addr[i], 0);
      chk("rst_pe_x0", i, pe_x0[i], 0); chk("rst_pe_x1", i, pe_x1[i], 0);
      chk("rst_pe_w0", i, pe_w0[i], 0); chk("rst_pe_w1", i, pe_w1[i], 0);
      chk("rst_y_data", i, y_data[i], 0); chk("rst_y_idx", i, y_idx[i], 0);
    end
  endtask
  task automatic run_row(input bit rnd, input int stall_o, input int rst_o);
    int r0 = rows_done;
    int stall = 0;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    for (int c = 0; c < 600; c++) begin
      if (rows_done != r0) begin
        y_ready = 1;
        repeat (2) @(posedge clk);
        #1;
        return;
      end
      if (stall > 0) begin
        stall--;
        y_ready = stall == 0;
        start = stall == 5;
      end else if (trk && next_o == stall_o && k == P + 3) begin
        stall = 10;
        y_ready = 0;
      end else if (rst_o >= 0 && trk && next_o == rst_o && k == 1) begin
        rst = 1;
        #1 check_zero();
        @(posedge clk); #1;
        rst = 0;
        repeat (2) @(posedge clk);
        #1;
        return;
      end else y_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(posedge clk); #1;
    end
    nvec++; nerr++;
    $display("FAIL row_timeout: no completion after 600 cycles, got next_o=%0d, expected %0d", next_o, OUT_LEN - 1);
  endtask
  task automatic fill(input logic [15:0] xv, input logic [15:0] xs, input logic [15:0] wv, input logic [15:0] bv);
    for (int j = 0; j < IN_LEN; j++) xmem[j] = xv + 16'(j) * xs;
    for (int j = 0; j < N_TAPS; j++) wmem[j] = wv;
    bias = bv;
  endtask
  initial begin
    rst = 1; start = 0; y_ready = 1; bias = 0;
    for (int j = 0; j < 256; j++) xmem[j] = 0;
    for (int j = 0; j < N_TAPS; j++) wmem[j] = 0;
    repeat (3) @(posedge clk);
    #1 check_zero();
    rst = 0;
    @(posedge clk); #1;
    fill(16'h0100, 0, 16'h0100, 0);
    run_row(0, -1, -1);
    for (int o = 0; o < OUT_LEN; o++) begin
      chk("t1_y", o, got_y[0][o], 16'h0400);
      chk("t1_idx", o, got_idx[o], o);
      if (o > 0) chk("t1_spacing", o, hs_cyc[o] - hs_cyc[o - 1], 6);
    end
    fill(0, 16'h0100, 16'h0100, 16'h0080);
    run_row(0, -1, -1);
    for (int o = 0; o < OUT_LEN; o++) chk("t2_y", o, got_y[1][o], 16'h0680 + 16'(o) * 16'h0400);
    fill(16'h7fff, 0, 16'h7fff, 0);
    run_row(0, -1, -1);
    chk("t3_pos_sat_relu", 0, got_y[0][0], 16'h7fff);
    chk("t3_pos_sat", 4, got_y[1][4], 16'h7fff);
    fill(16'h7fff, 0, 16'h8000, 0);
    run_row(0, -1, -1);
    chk("t3_neg_sat", 0, got_y[1][0], 16'h8000);
    chk("t3_neg_relu", 0, got_y[0][0], 16'h0000);
    fill(16'h0100, 0, 16'hff00, 0);
    run_row(0, -1, -1);
    for (int o = 0; o < OUT_LEN; o++) chk("t4_relu", o, got_y[0][o], 16'h0000);
    chk("t4_norelu", 2, got_y[1][2], 16'hfc00);
    fill(0, 16'h0100, 16'h0100, 16'h0080);
    run_row(0, 2, -1);
    chk("t5_stall_gap", 2, hs_cyc[2] - hs_cyc[1], 16);
    chk("t5_after_stall", 3, got_y[0][3], 16'h1280);
    run_row(0, -1, 3);
    for (int o = 0; o < OUT_LEN; o++) got_idx[o] = 8'hff;
    run_row(0, -1, -1);
    for (int o = 0; o < OUT_LEN; o++) chk("t6_restart_idx", o, got_idx[o], o);
    chk("t6_restart_y", 0, got_y[0][0], 16'h0680);
    for (int row = 0; row < 12; row++) begin
      bit wide = row[0];
      for (int j = 0; j < IN_LEN; j++) xmem[j] = wide ? 16'($urandom) : 16'($urandom_range(0, 2047)) - 16'd1024;
      for (int j = 0; j < N_TAPS; j++) wmem[j] = wide ? 16'($urandom) : 16'($urandom_range(0, 1023)) - 16'd512;
      bias = 16'($urandom_range(0, 4095)) - 16'd2048;
      run_row(1, -1, -1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/conv2_pe_sequencer.md
Name: conv2_pe_sequencer

Overview:
Drives one two-tap conv2 processing element (PE) to compute a 1-D stride-1 convolution over a buffered input row. Each cycle it fetches a sample pair and a weight pair, issues them to the PE, and accumulates the PE's partial sums. It then adds bias, rescales, applies ReLU and saturation, and streams results out with a valid/ready handshake. It sits between the conv2 input line buffer / weight ROM and the conv2 output buffer.

Parameters:
N_TAPS, 8, kernel length; must be even (PE consumes 2 taps/cycle); P = N_TAPS/2 pairs per output
IN_LEN, 64, input samples per row; OUT_LEN = IN_LEN - N_TAPS + 1
ADDR_W, 8, input buffer address width
ACC_W, 40, accumulator width
RELU, 1, 1 = clamp negative results to 0

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
start  in  1  begin one row; sampled only in IDLE
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last output handshake
x_addr0  out  ADDR_W  input buffer read address, port 0
x_addr1  out  ADDR_W  input buffer read address, port 1
x_rd_en  out  1  read strobe; data returns 1 cycle later
x_rdata0  in  16  signed Q8.8 sample at x_addr0
x_rdata1  in  16  signed Q8.8 sample at x_addr1
w_addr  out  clog2(P)  weight-pair index; same-cycle strobe as x_rd_en, 1-cycle latency
w_rdata0  in  16  signed Q8.8 tap 2p
w_rdata1  in  16  signed Q8.8 tap 2p+1
bias  in  16  signed Q8.8; held stable while busy
pe_start  out  1  PE operand-valid strobe
pe_x0, pe_x1, pe_w0, pe_w1  out  16 each  PE operands
pe_odata  in  32  PE sum, Q16.16, valid the cycle after pe_start
y_data  out  16  signed Q8.8 result
y_idx  out  ADDR_W  output position of y_data
y_valid  out  1  result valid
y_ready  in  1  downstream accept

Behaviour:
- Reset (async, any state): state IDLE. busy, done, x_rd_en, pe_start, y_valid = 0. All address, operand and data outputs = 0. Accumulator cleared.
- States: IDLE -> FETCH -> DRAIN -> OUT -> (FETCH for next output | DONE) -> IDLE.
- IDLE: start=1 sets output index o=0, sets busy, goes to FETCH. start while busy is ignored.
- FETCH: runs P cycles with pair p=0..P-1. Drives x_rd_en=1, x_addr0=o+2p, x_addr1=o+2p+1, w_addr=p. Accumulator clears at p=0.
- Operand stage: one cycle after each read, pe_start=1 and pe_x0/x1/w0/w1 = registered copies of x_rdata0/x_rdata1/w_rdata0/w_rdata1.
- Accumulate stage: one cycle after pe_start, acc += sign-extended pe_odata. PE 32-bit overflow is the PE's wrap; the accumulator itself does not wrap for in-range Q8.8 data.
- DRAIN: 2 cycles, waiting for the last pair's accumulate. Then the result is computed as r = (acc + (sign-ext bias << 8)) >>> 8 (arithmetic shift, truncation).
  - If RELU=1 and r<0, then r=0.
  - Saturate r to [-32768, 32767].
  - Register the result into y_data, set y_idx=o, assert y_valid, enter OUT.
- OUT: y_data, y_idx and y_valid are held stable until y_valid & y_ready.
  - On handshake: y_valid drops the next cycle. If o = OUT_LEN-1, go to DONE; else increment o and go to FETCH.
- Throughput: with y_ready held high, an output takes P+3 cycles from FETCH entry to y_valid rise, plus 1 handshake cycle.
- DONE: done=1 for exactly one cycle, busy drops the same cycle, return to IDLE.
- No pe_start is issued outside the FETCH+1 window. pe_start stays low during OUT stalls.
- Reset mid-row: the row is abandoned. No done pulse is issued. The next start recomputes from o=0.

Test Plan:
- N_TAPS=4, IN_LEN=8, all x=0x0100, all w=0x0100, bias=0, y_ready=1 -> 5 outputs with y_data=0x0400, y_idx=0..4; done pulses once; each output is spaced 6 cycles apart.
- Same setup with x[i]=i·0x0100, w=0x0100, bias=0x0080 -> y_data for o is (4o+6)·0x0100+0x0080, i.e. 0x0680, 0x0A80, 0x0E80, 0x1280, 0x1680.
- All x=0x7FFF, all w=0x7FFF -> y_data=0x7FFF (positive saturation). With RELU=0 and w=0x8000 -> y_data=0x8000.
- RELU=1, x=0x0100, w=0xFF00 (-1.0), bias=0 -> every y_data=0x0000.
- y_ready held low 10 cycles at o=2 -> y_data/y_idx/y_valid stable throughout, no pe_start toggling, output resumes in order; a start pulse during the stall is ignored.
- Assert rst during FETCH of o=3 -> all outputs 0 immediately, no done pulse; a new start produces the full sequence from y_idx=0.
